// File: rtl/lsu_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_sequencer
// Description : Data-memory initiator for the load/store stage. It issues only
//               full-word, word-aligned accesses, splits accesses that cross a
//               word boundary into two words, performs sub-word stores as
//               read-modify-write and sign/zero-extends load results.
//               Optional build macro MISALIGN_TRAP_EN: when defined, a
//               misaligned H/W access returns rsp_err and never touches memory.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_sequencer #(
    parameter logic [2:0] DMCTRL_WORD = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        DMWr,
    output logic [2:0]  DMCtrl,
    output logic [31:0] Address,
    output logic [31:0] DataWr,
    input  logic [31:0] DataRd
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD0  = 3'd1;
    localparam logic [2:0] S_RD1  = 3'd2;
    localparam logic [2:0] S_WR0  = 3'd3;
    localparam logic [2:0] S_WR1  = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    logic [2:0]  r_state;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [2:0]  r_size;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic [63:0] r_buf;       // {second word, first word} as read/merged
    logic [31:0] r_addr;
    logic [31:0] r_datawr;
    logic        r_dmwr;
    logic        r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic [2:0]  w_req_size;
    logic        w_misalign;
    logic        w_illegal;
    logic        w_cross;
    logic [63:0] w_buf_rd;
    logic [63:0] w_merged;
    logic [31:0] w_load_data;

    // Insert the right-aligned store data at byte offset off of the 8-byte window.
    function automatic logic [63:0] merge(input logic [63:0] b, input logic [1:0] off,
                                          input logic [2:0] size, input logic [31:0] wd);
        logic [31:0] bm;
        logic [63:0] m;
        logic [63:0] d;
        case (size)
            3'd1:    bm = 32'h0000_00FF;
            3'd2:    bm = 32'h0000_FFFF;
            default: bm = 32'hFFFF_FFFF;
        endcase
        m = {32'h0, bm} << {off, 3'b000};
        d = {32'h0, wd} << {off, 3'b000};
        return (b & ~m) | (d & m);
    endfunction

    // Pull the addressed bytes out of the 8-byte window and extend them.
    function automatic logic [31:0] extract(input logic [63:0] b, input logic [1:0] off,
                                            input logic [2:0] f3);
        logic [63:0] s;
        s = b >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return s[31:0];
        endcase
    endfunction

    assign w_req_size = (req_funct3[1:0] == 2'b00) ? 3'd1 :
                        (req_funct3[1:0] == 2'b01) ? 3'd2 : 3'd4;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111) || (req_we && req_funct3[2]) || w_misalign;

    assign w_cross = (({1'b0, r_off} + r_size) > 3'd4);

    // Read buffer as it will look after this cycle's DataRd is captured.
    always_comb begin
        w_buf_rd = r_buf;
        if (r_state == S_RD0) w_buf_rd[31:0]  = DataRd;
        if (r_state == S_RD1) w_buf_rd[63:32] = DataRd;
    end

    assign w_merged    = merge(w_buf_rd, r_off, r_size, r_wdata);
    assign w_load_data = extract(w_buf_rd, r_off, r_f3);

    // Access sequencing; every memory-side and response output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
            r_size      <= 3'd1;
            r_base      <= 32'h0;
            r_wdata     <= 32'h0;
            r_buf       <= 64'h0;
            r_addr      <= 32'h0;
            r_datawr    <= 32'h0;
            r_dmwr      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
        end else begin
            r_dmwr      <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_f3    <= req_funct3;
                        r_off   <= req_addr[1:0];
                        r_size  <= w_req_size;
                        r_base  <= {req_addr[31:2], 2'b00};
                        r_wdata <= req_wdata;
                        if (w_illegal) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'h0;
                        end else if (req_we && (req_funct3 == 3'b010) && (req_addr[1:0] == 2'b00)) begin
                            // Aligned full-word store needs no read of the old word.
                            r_state  <= S_WR0;
                            r_addr   <= {req_addr[31:2], 2'b00};
                            r_datawr <= req_wdata;
                            r_dmwr   <= 1'b1;
                        end else begin
                            r_state <= S_RD0;
                            r_addr  <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                S_RD0, S_RD1: begin
                    r_buf <= w_buf_rd;
                    if ((r_state == S_RD0) && w_cross) begin
                        r_state <= S_RD1;
                        r_addr  <= r_base + 32'd4;
                    end else if (r_we) begin
                        r_state  <= S_WR0;
                        r_addr   <= r_base;
                        r_buf    <= w_merged;
                        r_datawr <= w_merged[31:0];
                        r_dmwr   <= 1'b1;
                    end else begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= w_load_data;
                    end
                end
                S_WR0: begin
                    if (w_cross) begin
                        r_state  <= S_WR1;
                        r_addr   <= r_base + 32'd4;
                        r_datawr <= r_buf[63:32];
                        r_dmwr   <= 1'b1;
                    end else begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= 32'h0;
                    end
                end
                S_WR1: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'h0;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Reset gates the write strobe immediately so an aborted store never commits.
    assign DMWr      = r_dmwr && !rst;
    assign req_ready = (r_state == S_IDLE) && !rst;
    assign DMCtrl    = DMCTRL_WORD;
    assign Address   = r_addr;
    assign DataWr    = r_datawr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_sequencer
// Description : Directed self-checking bench for lsu_mem_sequencer with an
//               8-word memory model indexed by Address[4:2] (0xFFFFFFFC -> 7).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic [31:0] DataRd;

    logic [31:0] mem [0:7];
    logic        pl_en = 1'b0;
    logic [2:0]  pl_idx = 3'd0;
    logic [31:0] pl_data = 32'h0;

    int cmp  = 0;
    int errs = 0;

    lsu_mem_sequencer #(.DMCTRL_WORD(3'b000)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .DMWr(DMWr), .DMCtrl(DMCtrl), .Address(Address),
        .DataWr(DataWr), .DataRd(DataRd)
    );

    always #5 clk = ~clk;

    always_comb DataRd = mem[Address[4:2]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (DMWr) mem[Address[4:2]] <= DataWr;
    end

    task automatic poke(input logic [2:0] idx, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // One request; records latency, response, write count, per-cycle Address/DataWr.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic e,
                          output logic [31:0] rd, output int nwr,
                          output logic [31:0] a1, output logic [31:0] a2,
                          output logic [31:0] dw1, output logic [31:0] dw2,
                          output logic rdy_resp, output logic rdy_after);
        lat = 0; e = 1'bx; rd = 32'hx; nwr = 0; a1 = 32'hx; a2 = 32'hx;
        dw1 = 32'hx; dw2 = 32'hx; rdy_resp = 1'bx; rdy_after = 1'bx;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) a1 = Address;
            if (k == 2) a2 = Address;
            if (DMWr) begin
                nwr++;
                if (nwr == 1) dw1 = DataWr;
                if (nwr == 2) dw2 = DataWr;
            end
            if (rsp_valid) begin
                lat = k; e = rsp_err; rd = rsp_rdata; rdy_resp = req_ready;
                break;
            end
        end
        @(negedge clk);
        rdy_after = req_ready;
        if (rsp_valid) lat = -1;
    endtask

    int lat, nwr;
    logic e, rr, ra;
    logic [31:0] rd, a1, a2, dw1, dw2;

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp++; if (req_ready !== 1'b0) begin errs++; $display("FAIL reset_ready_in_rst: got %b want 0", req_ready); end
        cmp++; if ({rsp_valid, rsp_err, DMWr} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b want 000", {rsp_valid, rsp_err, DMWr}); end
        cmp++; if ({Address, DataWr, rsp_rdata} !== 96'h0) begin errs++; $display("FAIL reset_regs: got %h want 0", {Address, DataWr, rsp_rdata}); end
        cmp++; if (DMCtrl !== 3'b000) begin errs++; $display("FAIL dmctrl: got %b want 000", DMCtrl); end
        rst = 1'b0;
        @(negedge clk);
        cmp++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_ready_after: got %b want 1", req_ready); end
    endtask

    task automatic test_word();
        do_req(1'b1, 3'b010, 32'h0, 32'hABCD1234, lat, e, rd, nwr, a1, a2, dw1, dw2, rr, ra);
        cmp++; if (lat !== 2) begin errs++; $display("FAIL sw_lat: got %0d want 2", lat); end
        cmp++; if (nwr !== 1) begin errs++; $display("FAIL sw_nwr: got %0d want 1", nwr); end
        cmp++; if (a1 !== 32'h0 || dw1 !== 32'hABCD1234) begin errs++; $display("FAIL sw_bus: got %h/%h want 0/abcd1234", a1, dw1); end
        cmp++; if (mem[0] !== 32'hABCD1234) begin errs++; $display("FAIL sw_mem: got %h want abcd1234", mem[0]); end
        cmp++; if (e !== 1'b0 || rd !== 32'h0) begin errs++; $display("FAIL sw_rsp: got %b/%h want 0/0", e, rd); end
        do_req(1'b0, 3'b010, 32'h0, 32'h0, lat, e, rd, nwr, a1, a2, dw1, dw2, rr, ra);
        cmp++; if (lat !== 2) begin errs++; $display("FAIL lw_lat: got %0d want 2", lat); end
        cmp++; if (rd !== 32'hABCD1234 || e !== 1'b0) begin errs++; $display("FAIL lw_data: got %h/%b want abcd1234/0", rd, e); end
        cmp++; if (nwr !== 0) begin errs++; $display("FAIL lw_nwr: got %0d want 0", nwr); end
    endtask

    task automatic test_byte();
        poke(3'd1, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h5, 32'h000000FF, lat, e, rd, nwr, a1, a2, dw1, dw2, rr, ra);
        cmp++; if (lat !== 3 || nwr !== 1) begin errs++; $display("FAIL sb_lat_nwr: got %0d/%0d want 3/1", lat, nwr); end
        cmp++; if (mem[1] !== 32'h1122FF44) begin errs++; $display("FAIL sb_mem: got %h want 1122ff44", mem[1]); end
        do_req(1'b0, 3'b000, 32'h5, 32'h0, lat, e, rd, nwr, a1, a2, dw1, dw2, rr, ra);
        cmp++; if (rd !== 32'hFFFFFFFF || lat !== 2) begin errs++; $display("FAIL lb: got %h/%0d want ffffffff/2", rd, lat); end
        do_req(1'b0, 3'b100, 32'h5, 32'h0, lat, e, rd, nwr, a1, a2, dw1, dw2, rr, ra);
        cmp++; if (rd !== 32'h000000FF) begin errs++; $display("FAIL lbu: got %h want 000000ff", rd); end
    endtask

    task automatic test_cross();
        poke(3'd1, 32'h11223344);
        poke(3'd2, 32'h55667788);
        do_req(1'b1, 3'b001, 32'h7, 32'h0000BEEF, lat, e, rd, nwr, a1, a2, dw1, dw2, rr, ra);
        cmp++; if (lat !== 5 || nwr !== 2) begin errs++; $display("FAIL sh_x_lat_nwr: got %0d/%0d want 5/2", lat, nwr); end
        cmp++; if (mem[1] !== 32'hEF223344 || mem[2] !== 32'h556677BE) begin errs++; $display("FAIL sh_x_mem: got %h/%h want ef223344/556677be", mem[1], mem[2]); end
        do_req(1'b0, 3'b001, 32'h7, 32'h0, lat, e, rd, nwr, a1, a2, dw1, dw2, rr, ra);
        cmp++; if (rd !== 32'hFFFFBEEF || lat !== 3) begin errs++; $display("FAIL lh_x: got %h/%0d want ffffbeef/3", rd, lat); end
        do_req(1'b0, 3'b101, 32'h6, 32'h0, lat, e, rd, nwr, a1, a2, dw1, dw2, rr, ra);
        cmp++; if (rd !== 32'h0000EF22 || lat !== 2) begin errs++; $display("FAIL lhu: got %h/%0d want 0000ef22/2", rd, lat); end
        do_req(1'b0, 3'b001, 32'h6, 32'h0, lat, e, rd, nwr, a1, a2, dw1, dw2, rr, ra);
        cmp++; if (rd !== 32'hFFFFEF22) begin errs++; $display("FAIL lh_sign: got %h want ffffef22", rd); end
    endtask

    task automatic test_wrap();
        poke(3'd7, 32'hCAFE0000);
        poke(3'd0, 32'h0000BABE);
        do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, lat, e, rd, nwr, a1, a2, dw1, dw2, rr, ra);
`ifdef MISALIGN_TRAP_EN
        cmp++; if (e !== 1'b1 || lat !== 1 || rd !== 32'h0) begin errs++; $display("FAIL lw_wrap_trap: got %b/%0d/%h want 1/1/0", e, lat, rd); end
`else
        cmp++; if (rd !== 32'hBABECAFE || lat !== 3 || e !== 1'b0) begin errs++; $display("FAIL lw_wrap: got %h/%0d/%b want babecafe/3/0", rd, lat, e); end
        cmp++; if (a1 !== 32'hFFFFFFFC || a2 !== 32'h0) begin errs++; $display("FAIL lw_wrap_addr: got %h/%h want fffffffc/00000000", a1, a2); end
`endif
    endtask

    task automatic test_illegal();
        do_req(1'b0, 3'b011, 32'h10, 32'h0, lat, e, rd, nwr, a1, a2, dw1, dw2, rr, ra);
        cmp++; if (e !== 1'b1 || rd !== 32'h0 || lat !== 1 || nwr !== 0) begin errs++; $display("FAIL ill_ld: got %b/%h/%0d/%0d want 1/0/1/0", e, rd, lat, nwr); end
        do_req(1'b1, 3'b100, 32'h10, 32'h5A, lat, e, rd, nwr, a1, a2, dw1, dw2, rr, ra);
        cmp++; if (e !== 1'b1 || lat !== 1 || nwr !== 0) begin errs++; $display("FAIL ill_st: got %b/%0d/%0d want 1/1/0", e, lat, nwr); end
    endtask

    task automatic test_back_to_back();
        do_req(1'b0, 3'b010, 32'h4, 32'h0, lat, e, rd, nwr, a1, a2, dw1, dw2, rr, ra);
        cmp++; if (rr !== 1'b0 || ra !== 1'b1) begin errs++; $display("FAIL b2b_ready: got %b/%b want 0/1", rr, ra); end
        cmp++; if (lat !== 2) begin errs++; $display("FAIL b2b_lat: got %0d want 2", lat); end
    endtask

    task automatic test_abort();
        logic seen;
        poke(3'd0, 32'h0);
        poke(3'd1, 32'hAAAAAAAA);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h2; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        cmp++; if (DMWr !== 1'b0) begin errs++; $display("FAIL abort_dmwr: got %b want 0", DMWr); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        cmp++; if (req_ready !== 1'b1) begin errs++; $display("FAIL abort_ready: got %b want 1", req_ready); end
        seen = rsp_valid;
        repeat (4) begin @(negedge clk); seen = seen | rsp_valid; end
        cmp++; if (seen !== 1'b0) begin errs++; $display("FAIL abort_rsp: got %b want 0", seen); end
        cmp++; if (mem[1] !== 32'hAAAAAAAA || mem[0] !== 32'h56780000) begin errs++; $display("FAIL abort_mem: got %h/%h want aaaaaaaa/56780000", mem[1], mem[0]); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        test_reset();
        test_word();
        test_byte();
`ifndef MISALIGN_TRAP_EN
        test_cross();
`endif
        test_wrap();
        test_illegal();
        test_back_to_back();
`ifndef MISALIGN_TRAP_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_sequencer.md
Name: lsu_mem_sequencer

Overview:
- Initiator side of the data-memory port: sits between the core's load/store stage and DataMemory, and drives DMWr, DMCtrl, Address and DataWr while consuming DataRd.
- Accepts one load/store request at a time, using RISC-V funct3 encoding.
- Issues only full-word, word-aligned accesses to memory, and splits boundary-crossing accesses into two words.
- Sub-word stores are done as read-modify-write. Load results are extracted and sign- or zero-extended.

Parameters:
- DMCTRL_WORD, 3'b000, DMCtrl code driven on every memory access (full-word mode of DataMemory).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE and while rst is low.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  valid with rsp_valid; illegal funct3.
- rsp_rdata  out  32  load result, valid with rsp_valid; 0 for stores and errors.
- DMWr  out  1  memory write enable.
- DMCtrl  out  3  always DMCTRL_WORD.
- Address  out  32  word-aligned memory address (bits [1:0] = 0).
- DataWr  out  32  memory write data.
- DataRd  in  32  memory read data; combinational from Address, same cycle.

Behaviour:
- Memory contract:
  - DataRd is valid in the same cycle Address is driven.
  - A write commits at the rising edge that ends a cycle with DMWr=1.
- Reset state (rst high at an edge):
  - state=IDLE; rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - Address=0, DataWr=0.
  - DMWr is gated by !rst combinationally, so no write occurs in any cycle with rst high, including mid-operation. An aborted request produces no response.
- Request accept: accepted at the edge where req_valid && req_ready. Latch op, off=addr[1:0], size (1/2/4), base=addr&~3, wdata.
- Crossing: cross = (off+size > 4). The second word address is base+4, wrapping modulo 2^32 (0xFFFFFFFC → 0x00000000).
- Illegal: funct3 in {011, 110, 111}, or store with 100/101. Go straight to RESP with rsp_err=1. No memory access.
- FSM states: IDLE, RD0, RD1, WR0, WR1, RESP.
  - IDLE → RD0 on accept. Exceptions: aligned SW goes IDLE → WR0; illegal goes IDLE → RESP.
  - RD0: Address=base; capture DataRd into buf0. Next: RD1 if cross; else WR0 if store; else RESP.
  - RD1: Address=base+4; capture DataRd into buf1. Next: WR0 if store, else RESP.
  - WR0: Address=base; DMWr=1; DataWr=buf0 with the store bytes at off..min(off+size,4)-1 replaced by the low wdata bytes. Next: WR1 if cross, else RESP.
  - WR1: Address=base+4; DMWr=1; DataWr=buf1 with bytes 0..(off+size-5) replaced by the remaining wdata bytes. Next: RESP.
  - RESP: rsp_valid=1 for exactly one cycle. For loads, rsp_rdata=extend(({buf1,buf0} >> 8*off)[8*size-1:0]), where extend is sign for B/H and zero for BU/HU/W. Next: IDLE.
- rsp_valid timing, counted in cycles after the accept edge:
  - Aligned/non-crossing load: 2.
  - Crossing load: 3.
  - Aligned SW: 2.
  - Non-crossing sub-word store: 3.
  - Crossing store: 5.
  - Illegal: 1.
- Outside RD*/WR* states, DMWr=0 and Address/DataWr hold their last values.
- Back-to-back: req_ready rises in the cycle after RESP. There is no request overlap.

Optional Feature:
- MISALIGN_TRAP_EN: when defined, any access not naturally aligned (H with addr[0]≠0, W with addr[1:0]≠0) is treated like an illegal access: RESP with rsp_err=1 and no memory access. RD1/WR1 are unreachable and may be omitted.
- When undefined, such accesses are split as described in Behaviour.

Test Plan:
- SW 0xABCD1234 @0x0, then LW @0x0 → exactly one DMWr cycle with Address=0x0, DataWr=0xABCD1234, no read cycle; LW rsp_rdata=0xABCD1234, rsp_valid 2 cycles after accept.
- mem[0x4]=0x11223344; SB 0x000000FF @0x5 → mem[0x4]=0x1122FF44; LB @0x5 → 0xFFFFFFFF; LBU @0x5 → 0x000000FF.
- mem[0x4]=0x11223344, mem[0x8]=0x55667788; SH 0x0000BEEF @0x7 → mem[0x4]=0xEF223344, mem[0x8]=0x556677BE, rsp_valid 5 cycles after accept; LH @0x7 → 0xFFFFBEEF.
- mem[0xFFFFFFFC]=0xCAFE0000, mem[0x0]=0x0000BABE; LW @0xFFFFFFFE → reads at 0xFFFFFFFC then 0x00000000, rsp_rdata=0xBABECAFE (with MISALIGN_TRAP_EN defined: rsp_err=1, no access).
- Load with funct3=011 @0x10 → rsp_err=1, rsp_rdata=0, DMWr never high, rsp_valid 1 cycle after accept.
- Crossing SW 0x12345678 @0x2, rst asserted in the WR1 cycle → DMWr=0 that cycle, mem[0x4] unchanged, no rsp_valid, req_ready=1 the cycle after rst drops.
